// File: rtl/dram_cmd_responder.sv
`timescale 1ns/1ps
// DRAM-side command decoder, per-bank timing checker and burst beat generator.
// Violations report one cycle after the command; beats start T_RL/T_WL cycles after RD/WR; no backpressure.
module dram_cmd_responder #(
    parameter int T_RCD   = 10,
    parameter int T_RAS   = 10,
    parameter int T_RP    = 10,
    parameter int T_RFC   = 10,
    parameter int T_RL    = 11,
    parameter int T_WL    = 11,
    parameter int T_BURST = 4,
    parameter int ROW_W   = 15,
    parameter int COL_W   = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       cmd,
    input  logic [1:0]       bg,
    input  logic [1:0]       ba,
    input  logic [ROW_W-1:0] addr,
    output logic             rd_beat,
    output logic             wr_beat,
    output logic [3:0]       beat_bank,
    output logic [ROW_W-1:0] beat_row,
    output logic [COL_W-1:0] beat_col,
    output logic             refreshing,
    output logic             viol,
    output logic [3:0]       viol_code
);
    localparam int PIPE_D = ((T_RL > T_WL) ? T_RL : T_WL) - 1;
    localparam int RD_TAP = T_RL - 2;
    localparam int WR_TAP = T_WL - 2;
    localparam int REF_W  = $clog2(T_RFC + 1);
    localparam int BL_W   = $clog2(T_BURST + 1);
    localparam logic [5:0] RCD_C   = 6'(T_RCD);
    localparam logic [5:0] RAS_C   = 6'(T_RAS);
    localparam logic [5:0] RP_C    = 6'(T_RP);
    localparam logic [5:0] BURST_C = 6'(T_BURST);
    localparam logic [REF_W-1:0] RFC_C  = REF_W'(T_RFC);
    localparam logic [BL_W-1:0]  BL_TOP = BL_W'(T_BURST - 1);

    typedef struct packed {
        logic             is_wr;
        logic [3:0]       bank;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } pipe_t;

    logic [15:0]      open_q;
    logic [5:0]       cnt_q [16];
    logic [ROW_W-1:0] row_q [16];
    logic [5:0]       ccd_q;
    logic [REF_W-1:0] ref_q;
    logic [PIPE_D-1:0] pvld_q;
    pipe_t            pipe_q [PIPE_D];
    logic [BL_W-1:0]  left_q;
    logic             rd_beat_q, wr_beat_q, viol_q;
    logic [3:0]       bank_q, code_q;
    logic [ROW_W-1:0] brow_q;
    logic [COL_W-1:0] col_q;

    logic [3:0]  bk;
    logic        cs_n, act_n;
    logic [2:0]  rcw;
    logic        is_act, is_ref, is_pre, is_rw, is_wr_cmd, is_mz, is_ill, is_nop;
    logic        any_open, ras_fail_all, cmd_ok;
    logic        act_go, pre_go, ref_go, rw_go, rd_launch, wr_launch;
    logic [10:1] fail_d;
    logic        viol_d;
    logic [3:0]  code_d;
    pipe_t       launch_e;

    assign refreshing = (ref_q != '0);

    always_comb begin
        bk        = {bg, ba};
        cs_n      = cmd[4];
        act_n     = cmd[3];
        rcw       = cmd[2:0];
        is_act    = !cs_n && !act_n;
        is_ref    = !cs_n && act_n && (rcw == 3'b001);
        is_pre    = !cs_n && act_n && (rcw == 3'b010);
        is_rw     = !cs_n && act_n && (rcw[2:1] == 2'b10);
        is_wr_cmd = !rcw[0];
        is_mz     = !cs_n && act_n && ((rcw == 3'b000) || (rcw == 3'b110));
        is_ill    = !cs_n && act_n && (rcw == 3'b011);
        is_nop    = !cs_n && act_n && (rcw == 3'b111);
        any_open  = |open_q;
        ras_fail_all = 1'b0;
        for (int b = 0; b < 16; b++) begin
            if (open_q[b] && (cnt_q[b] < RAS_C)) ras_fail_all = 1'b1;
        end
        // One bit per violation code; the lowest set bit is reported.
        fail_d     = '0;
        fail_d[1]  = is_ill;
        fail_d[2]  = is_act && open_q[bk];
        fail_d[3]  = is_rw && !open_q[bk];
        fail_d[4]  = is_rw && open_q[bk] && (cnt_q[bk] < RCD_C);
        fail_d[5]  = is_pre && (addr[10] ? ras_fail_all : (open_q[bk] && (cnt_q[bk] < RAS_C)));
        fail_d[6]  = is_act && (cnt_q[bk] < RP_C);
        fail_d[7]  = (refreshing && !cs_n && !is_nop) || (is_ref && any_open);
        fail_d[8]  = is_rw && (ccd_q < BURST_C);
        fail_d[9]  = is_mz && any_open;
        cmd_ok     = !(|fail_d[9:1]);
        act_go     = is_act && cmd_ok;
        pre_go     = is_pre && cmd_ok;
        ref_go     = is_ref && cmd_ok;
        rw_go      = is_rw && cmd_ok;
        rd_launch  = pvld_q[RD_TAP] && !pipe_q[RD_TAP].is_wr;
        wr_launch  = pvld_q[WR_TAP] && pipe_q[WR_TAP].is_wr;
        fail_d[10] = rd_launch && wr_launch;
        launch_e   = rd_launch ? pipe_q[RD_TAP] : pipe_q[WR_TAP];
        viol_d     = |fail_d;
        code_d     = '0;
        for (int i = 10; i >= 1; i--) begin
            if (fail_d[i]) code_d = 4'(i);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            open_q    <= '0;
            ccd_q     <= '1;
            ref_q     <= '0;
            pvld_q    <= '0;
            left_q    <= '0;
            rd_beat_q <= 1'b0;
            wr_beat_q <= 1'b0;
            bank_q    <= '0;
            brow_q    <= '0;
            col_q     <= '0;
            viol_q    <= 1'b0;
            code_q    <= '0;
            for (int b = 0; b < 16; b++) begin
                cnt_q[b] <= '1;
                row_q[b] <= '0;
            end
            for (int i = 0; i < PIPE_D; i++) pipe_q[i] <= '0;
        end else begin
            // Counters load 1 so they read as cycles elapsed since the ACT/PRE cycle.
            for (int b = 0; b < 16; b++) begin
                if ((act_go && (bk == 4'(b))) ||
                    (pre_go && open_q[b] && (addr[10] || (bk == 4'(b)))))
                    cnt_q[b] <= 6'd1;
                else if (cnt_q[b] != '1)
                    cnt_q[b] <= cnt_q[b] + 6'd1;
                if (pre_go && (addr[10] || (bk == 4'(b)))) open_q[b] <= 1'b0;
            end
            if (act_go) begin
                open_q[bk] <= 1'b1;
                row_q[bk]  <= addr;
            end
            if (rw_go)               ccd_q <= 6'd1;
            else if (ccd_q != '1)    ccd_q <= ccd_q + 6'd1;
            if (ref_go)              ref_q <= RFC_C;
            else if (ref_q != '0)    ref_q <= ref_q - REF_W'(1);
            pvld_q[0] <= rw_go;
            pipe_q[0] <= {is_wr_cmd, bk, row_q[bk], addr[COL_W-1:0]};
            for (int i = 1; i < PIPE_D; i++) begin
                pvld_q[i] <= pvld_q[i-1];
                pipe_q[i] <= pipe_q[i-1];
            end
            // A simultaneous write launch loses to the read and is reported as code 10.
            if (rd_launch || wr_launch) begin
                rd_beat_q <= rd_launch;
                wr_beat_q <= !rd_launch;
                bank_q    <= launch_e.bank;
                brow_q    <= launch_e.row;
                col_q     <= launch_e.col;
                left_q    <= BL_TOP;
            end else if (left_q != '0) begin
                left_q    <= left_q - BL_W'(1);
                col_q     <= col_q + COL_W'(1);
            end else begin
                rd_beat_q <= 1'b0;
                wr_beat_q <= 1'b0;
                bank_q    <= '0;
                brow_q    <= '0;
                col_q     <= '0;
            end
            viol_q <= viol_d;
            code_q <= code_d;
        end
    end

    assign rd_beat   = rd_beat_q;
    assign wr_beat   = wr_beat_q;
    assign beat_bank = bank_q;
    assign beat_row  = brow_q;
    assign beat_col  = col_q;
    assign viol      = viol_q;
    assign viol_code = code_q;
endmodule

// File: tb/tb_dram_cmd_responder.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus queues expected beats/violations, a negedge monitor checks them.
module tb_dram_cmd_responder;
    localparam int LAT = 11;
    localparam logic [4:0] C_DESEL = 5'b11111;
    localparam logic [4:0] C_NOP   = 5'b01111;
    localparam logic [4:0] C_ACT   = 5'b00111;
    localparam logic [4:0] C_REF   = 5'b01001;
    localparam logic [4:0] C_PRE   = 5'b01010;
    localparam logic [4:0] C_WR    = 5'b01100;
    localparam logic [4:0] C_RD    = 5'b01101;
    localparam logic [4:0] C_MRS   = 5'b01000;
    localparam logic [4:0] C_ILL   = 5'b01011;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  cmd = C_DESEL;
    logic [1:0]  bg = '0, ba = '0;
    logic [14:0] addr = '0;
    logic        rd_beat, wr_beat, refreshing, viol;
    logic [3:0]  beat_bank, viol_code;
    logic [14:0] beat_row;
    logic [9:0]  beat_col;

    dram_cmd_responder dut (
        .CLK(CLK), .RST(RST), .cmd(cmd), .bg(bg), .ba(ba), .addr(addr),
        .rd_beat(rd_beat), .wr_beat(wr_beat), .beat_bank(beat_bank),
        .beat_row(beat_row), .beat_col(beat_col), .refreshing(refreshing),
        .viol(viol), .viol_code(viol_code)
    );

    always #5 CLK = ~CLK;

    typedef struct { int cyc; logic wr; logic [3:0] bank; logic [14:0] row; logic [9:0] col; } beat_t;
    typedef struct { int cyc; logic [3:0] code; } vexp_t;

    beat_t exp_beat[$];
    vexp_t exp_viol[$];
    logic [14:0] model_row [16];
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int ref_lo = -1;
    int ref_hi = -2;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        beat_t e;
        vexp_t v;
        logic  er;
        if (!RST) begin
            while (exp_beat.size() > 0 && exp_beat[0].cyc < cyc) begin
                e = exp_beat.pop_front();
                total++; bad++;
                $display("FAIL beat_missing: no beat seen, required one at cyc %0d col %h", e.cyc, e.col);
            end
            if (rd_beat || wr_beat) begin
                total++;
                if (exp_beat.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected: got rd=%b wr=%b col=%h at cyc %0d, required none", rd_beat, wr_beat, beat_col, cyc);
                end else begin
                    e = exp_beat.pop_front();
                    if (e.cyc != cyc || wr_beat !== e.wr || rd_beat !== !e.wr ||
                        beat_bank !== e.bank || beat_row !== e.row || beat_col !== e.col) begin
                        bad++;
                        $display("FAIL beat: got cyc=%0d rd=%b wr=%b bank=%0d row=%h col=%h, required cyc=%0d wr=%b bank=%0d row=%h col=%h",
                                 cyc, rd_beat, wr_beat, beat_bank, beat_row, beat_col, e.cyc, e.wr, e.bank, e.row, e.col);
                    end
                end
            end
            while (exp_viol.size() > 0 && exp_viol[0].cyc < cyc) begin
                v = exp_viol.pop_front();
                total++; bad++;
                $display("FAIL viol_missing: no viol seen, required code %0d at cyc %0d", v.code, v.cyc);
            end
            if (viol) begin
                total++;
                if (exp_viol.size() == 0) begin
                    bad++;
                    $display("FAIL viol_unexpected: got code %0d at cyc %0d, required none", viol_code, cyc);
                end else begin
                    v = exp_viol.pop_front();
                    if (v.cyc != cyc || viol_code !== v.code) begin
                        bad++;
                        $display("FAIL viol: got code %0d at cyc %0d, required code %0d at cyc %0d", viol_code, cyc, v.code, v.cyc);
                    end
                end
            end
            er = (cyc >= ref_lo) && (cyc <= ref_hi);
            total++;
            if (refreshing !== er) begin
                bad++;
                $display("FAIL refreshing: got %b at cyc %0d, required %b", refreshing, cyc, er);
            end
        end
    end

    task automatic go_to(input int t);
        while (cyc < t) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic issue(input int t, input logic [4:0] c, input logic [3:0] bk,
                         input logic [14:0] a, input logic [3:0] code);
        go_to(t);
        cmd = c; bg = bk[3:2]; ba = bk[1:0]; addr = a;
        if (code != 4'd0) exp_viol.push_back('{cyc + 1, code});
        @(posedge CLK); #1;
        cmd = C_NOP; addr = '0;
    endtask

    task automatic act(input int t, input logic [3:0] bk, input logic [14:0] row, input logic [3:0] code);
        if (code == 4'd0) model_row[bk] = row;
        issue(t, C_ACT, bk, row, code);
    endtask

    task automatic pre(input int t, input logic [3:0] bk, input logic all, input logic [3:0] code);
        logic [14:0] a;
        a = '0;
        a[10] = all;
        issue(t, C_PRE, bk, a, code);
    endtask

    task automatic rw(input int t, input logic wr, input logic [3:0] bk, input logic [9:0] col, input logic [3:0] code);
        logic [9:0] cc;
        if (code == 4'd0) begin
            for (int i = 0; i < 4; i++) begin
                cc = col + 10'(i);
                exp_beat.push_back('{t + LAT + i, wr, bk, model_row[bk], cc});
            end
        end
        issue(t, wr ? C_WR : C_RD, bk, {5'd0, col}, code);
    endtask

    initial begin
        #300000;
        total++; bad++;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, b2, a, p0, b, r, w, d, rel;
        for (int i = 0; i < 16; i++) model_row[i] = '0;
        #1;
        total++;
        if ({rd_beat, wr_beat, viol, refreshing, beat_bank, beat_row, beat_col, viol_code} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rd=%b wr=%b viol=%b ref=%b code=%0d col=%h, required all zero",
                     rd_beat, wr_beat, viol, refreshing, viol_code, beat_col);
        end
        repeat (3) @(posedge CLK);
        #1; RST = 1'b0; cmd = C_NOP;

        base = cyc + 2;
        act(base, 4'd6, 15'h1234, 4'd0);
        rw(base + 10, 1'b0, 4'd6, 10'h3FE, 4'd0);

        b2 = base + 30;
        act(b2, 4'd0, 15'h0055, 4'd0);
        rw(b2 + 5, 1'b0, 4'd0, 10'h010, 4'd4);

        a = b2 + 20;
        act(a, 4'd3, 15'h0333, 4'd0);
        pre(a + 4, 4'd3, 1'b0, 4'd5);
        act(a + 6, 4'd3, 15'h0333, 4'd2);
        pre(a + 10, 4'd3, 1'b0, 4'd0);
        act(a + 15, 4'd3, 15'h0333, 4'd6);

        p0 = a + 30;
        pre(p0, 4'd0, 1'b1, 4'd0);
        b = p0 + 15;
        act(b, 4'd0, 15'h0ABC, 4'd0);
        act(b + 1, 4'd5, 15'h0555, 4'd0);
        issue(b + 3, C_REF, 4'd0, 15'h0, 4'd7);
        pre(b + 5, 4'd0, 1'b1, 4'd5);
        pre(b + 11, 4'd0, 1'b1, 4'd0);
        r = b + 22;
        ref_lo = r + 1;
        ref_hi = r + 10;
        issue(r, C_REF, 4'd0, 15'h0, 4'd0);
        act(r + 4, 4'd0, 15'h0ABC, 4'd7);
        act(r + 10, 4'd0, 15'h0ABC, 4'd7);
        act(r + 11, 4'd0, 15'h0ABC, 4'd0);
        issue(r + 12, C_MRS, 4'd0, 15'h0, 4'd9);
        issue(r + 13, C_ILL, 4'd0, 15'h0, 4'd1);

        w = r + 30;
        rw(w, 1'b1, 4'd0, 10'h010, 4'd0);
        rw(w + 2, 1'b1, 4'd0, 10'h050, 4'd8);
        rw(w + 20, 1'b1, 4'd0, 10'h020, 4'd0);
        rw(w + 24, 1'b1, 4'd0, 10'h100, 4'd0);

        d = w + 45;
        rw(d, 1'b0, 4'd0, 10'h200, 4'd0);
        go_to(d + LAT + 1);
        @(negedge CLK); #2;
        exp_beat.delete();
        RST = 1'b1;
        #1;
        total++;
        if ({rd_beat, wr_beat, viol, refreshing, beat_bank, beat_row, beat_col, viol_code} !== '0) begin
            bad++;
            $display("FAIL reset_midburst: got rd=%b wr=%b col=%h row=%h, required all zero",
                     rd_beat, wr_beat, beat_col, beat_row);
        end
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
        rel = cyc;
        rw(rel + 2, 1'b0, 4'd0, 10'h200, 4'd3);
        act(rel + 4, 4'd0, 15'h0111, 4'd0);
        rw(rel + 14, 1'b0, 4'd0, 10'h3FF, 4'd0);

        go_to(rel + 50);
        total++;
        if (exp_beat.size() != 0) begin
            bad++;
            $display("FAIL beat_queue_end: got %0d pending, required 0", exp_beat.size());
        end
        total++;
        if (exp_viol.size() != 0) begin
            bad++;
            $display("FAIL viol_queue_end: got %0d pending, required 0", exp_viol.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
